// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants for the UART receive path (uart_ctrl, uart_rx_packer,
// uart_bridge). A word is BYTES_PER_WORD bytes of BYTE_W bits each.
package uart_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/uart_rx_packer_if.sv
// uart_rx_packer_if
// Word stream from the packer toward uart_bridge.
//   word_out   : FIFO head word (driven by master)
//   word_valid : word_out holds a valid word (driven by master)
//   word_ready : consumer accepts word_out (driven by slave)
interface uart_rx_packer_if
    import uart_pkg::*;
#(
    parameter int WORD_LEN = WORD_W
);

    logic [WORD_LEN-1:0] word_out;
    logic                word_valid;
    logic                word_ready;

    modport master (output word_out, output word_valid, input word_ready);
    modport slave  (input word_out, input word_valid, output word_ready);

endinterface

// File: rtl/uart_word_fifo.sv
// uart_word_fifo
// First-word-fall-through FIFO, DEPTH entries of WIDTH bits.
//   clk, rst_n : clock, synchronous active-low reset (pointers and level)
//   push       : write push_data when not full, or when full with a pop
//   push_data  : word to store
//   pop        : remove head word; ignored when empty
//   rd_data    : head word, zero while empty
//   level      : number of stored words
//   full/empty : status flags
module uart_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));

    // A pop on an empty FIFO does nothing, so a push into an empty FIFO
    // with word_ready high is stored rather than passed through.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign level   = cnt;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_packer.sv
// uart_rx_packer
// Packs received UART bytes little-endian into 32-bit words and queues
// them in a word FIFO toward uart_bridge.
//   clk, rst_n    : clock, synchronous active-low reset
//   uart_en       : block enable; when low, bytes and flush are ignored
//   rx_byte       : received byte, qualified by rx_byte_valid
//   rx_byte_valid : one-cycle byte strobe
//   flush         : one-cycle strobe, pushes a partial word zero-padded
//   wbus          : word stream (word_out / word_valid / word_ready)
//   fifo_level    : words stored in the FIFO
//   lane          : bytes held in the partial word
//   overflow      : sticky, a completed word was dropped
//   clr_ovf       : clears overflow
module uart_rx_packer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_LEN   = WORD_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_en,
    input  logic [BYTE_W-1:0]             rx_byte,
    input  logic                          rx_byte_valid,
    input  logic                          flush,
    uart_rx_packer_if.master              wbus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [LANE_W-1:0]             lane,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    logic [WORD_LEN-1:0] asm_reg;
    logic [WORD_LEN-1:0] asm_next;
    logic                byte_acc;
    logic                flush_acc;
    logic                word_done;
    logic                push_req;
    logic                pop_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;

    assign byte_acc  = uart_en & rx_byte_valid;
    assign flush_acc = uart_en & flush;

    // Assembly register with the current byte merged into its lane; this
    // is what gets pushed, so a byte arriving with flush is included.
    always_comb begin
        asm_next = asm_reg;
        if (byte_acc) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (lane == LANE_W'(k)) asm_next[BYTE_W*k +: BYTE_W] = rx_byte;
            end
        end
    end

    assign word_done = byte_acc & (lane == LANE_W'(BYTES_PER_WORD - 1));
    // Flush pushes only if at least one byte is held after this cycle's byte;
    // a completing byte already pushes, so it never causes a second push.
    assign push_req  = word_done | (flush_acc & ((lane != '0) | byte_acc));

    assign pop_req = wbus.word_valid & wbus.word_ready;
    assign drop    = push_req & fifo_full & ~pop_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane     <= '0;
            asm_reg  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_req) begin
                lane    <= '0;
                asm_reg <= '0;
            end else if (byte_acc) begin
                lane    <= lane + LANE_W'(1);
                asm_reg <= asm_next;
            end
            // A new drop wins over a simultaneous clear.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    uart_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_LEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (asm_next),
        .pop       (pop_req),
        .rd_data   (wbus.word_out),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wbus.word_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_packer.sv
module tb_uart_rx_packer;
    import uart_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_en;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       flush;
    logic       clr_ovf;
    logic [2:0] fifo_level;
    logic [1:0] lane;
    logic       overflow;

    uart_rx_packer_if #(.WORD_LEN(32)) wif ();

    uart_rx_packer #(.FIFO_DEPTH(DEPTH), .WORD_LEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_en       (uart_en),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .flush         (flush),
        .wbus          (wif),
        .fifo_level    (fifo_level),
        .lane          (lane),
        .overflow      (overflow),
        .clr_ovf       (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending bytes of the partial word, stored words, sticky flag.
    byte unsigned m_part[$];
    logic [31:0]  m_fifo[$];
    bit           m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit en, input bit vld, input byte unsigned b,
                              input bit fl, input bit rdy, input bit clr);
        int          pre = m_fifo.size();
        bit          popd = (pre != 0) && rdy;
        bit          have = 0;
        bit          drp = 0;
        logic [31:0] w = 0;
        if (en) begin
            if (vld) m_part.push_back(b);
            if (m_part.size() == 4 || (fl && m_part.size() != 0)) begin
                foreach (m_part[k]) w = w | (32'(m_part[k]) << (8 * k));
                m_part.delete();
                have = 1;
            end
        end
        if (popd) void'(m_fifo.pop_front());
        if (have) begin
            if (pre < DEPTH || popd) m_fifo.push_back(w);
            else drp = 1;
        end
        if (drp) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic compare_all();
        chk("valid", 32'(wif.word_valid), 32'(m_fifo.size() != 0));
        chk("level", 32'(fifo_level), 32'(m_fifo.size()));
        chk("lane", 32'(lane), 32'(m_part.size()));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        if (m_fifo.size() != 0) chk("word", wif.word_out, m_fifo[0]);
    endtask

    task automatic cycle(input bit en, input bit vld, input byte unsigned b,
                         input bit fl, input bit rdy, input bit clr);
        uart_en = en; rx_byte_valid = vld; rx_byte = b; flush = fl;
        wif.word_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        model_step(en, vld, b, fl, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        uart_en = 1'b1; rx_byte_valid = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
        wif.word_ready = 1'b0; rx_byte = 8'h00;
        @(posedge clk);
        m_part.delete(); m_fifo.delete(); m_ovf = 0;
        #1;
        chk("rst_lane", 32'(lane), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_valid", 32'(wif.word_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_word", wif.word_out, 0);
        rst_n = 1'b1;
    endtask

    task automatic send(input byte unsigned b, input bit rdy);
        cycle(1, 1, b, 0, rdy, 0);
    endtask

    initial begin
        do_reset();

        // Four bytes form one little-endian word, visible one edge later for one cycle.
        send(8'h11, 1); send(8'h22, 1); send(8'h33, 1);
        chk("t35_pre_valid", 32'(wif.word_valid), 0);
        send(8'h44, 1);
        chk("t35_word", wif.word_out, 32'h44332211);
        chk("t35_valid", 32'(wif.word_valid), 1);
        cycle(1, 0, 0, 0, 1, 0);
        chk("t35_valid_drop", 32'(wif.word_valid), 0);

        // Partial word flushed with zero padding; a second flush pushes nothing.
        send(8'hAA, 1); send(8'hBB, 1);
        cycle(1, 0, 0, 1, 1, 0);
        chk("t36_word", wif.word_out, 32'h0000BBAA);
        chk("t36_lane", 32'(lane), 0);
        cycle(1, 0, 0, 1, 1, 0);
        chk("t36_noflush", 32'(fifo_level), 0);

        // Twenty bytes with no consumer: four words kept, the fifth dropped.
        for (int i = 1; i <= 20; i++) send(byte'(i), 0);
        chk("t37_level", 32'(fifo_level), 4);
        chk("t37_ovf", 32'(overflow), 1);
        chk("t37_w0", wif.word_out, 32'h04030201);
        cycle(1, 0, 0, 0, 1, 0);
        chk("t37_w1", wif.word_out, 32'h08070605);
        cycle(1, 0, 0, 0, 1, 0);
        chk("t37_w2", wif.word_out, 32'h0C0B0A09);
        cycle(1, 0, 0, 0, 1, 0);
        chk("t37_w3", wif.word_out, 32'h100F0E0D);
        cycle(1, 0, 0, 0, 1, 0);
        chk("t37_empty", 32'(wif.word_valid), 0);
        cycle(1, 0, 0, 0, 0, 1);
        chk("t37_clr", 32'(overflow), 0);

        // Full FIFO: completing byte with a simultaneous pop is not dropped.
        for (int i = 0; i < 19; i++) send(byte'(8'h30 + i), 0);
        chk("t38_full", 32'(fifo_level), 4);
        send(8'h55, 1);
        chk("t38_level", 32'(fifo_level), 4);
        chk("t38_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 0);

        // Disabled block ignores bytes and flush but holds its lane.
        do_reset();
        send(8'hC1, 0); send(8'hC2, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, byte'(8'hE0 + i), i == 1, 0, 0);
        chk("t39_lane", 32'(lane), 2);
        send(8'hC3, 0); send(8'hC4, 0);
        chk("t39_word", wif.word_out, 32'hC4C3C2C1);

        // Reset mid-word with stored words discards everything.
        do_reset();
        for (int i = 0; i < 11; i++) send(byte'(8'h70 + i), 0);
        chk("t40_pre_lane", 32'(lane), 3);
        chk("t40_pre_level", 32'(fifo_level), 2);
        do_reset();
        send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 0);
        chk("t40_word", wif.word_out, 32'hD4D3D2D1);
        chk("t40_level", 32'(fifo_level), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
                      byte'($urandom), $urandom_range(0, 9) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
